prbs_checker: RTL and testbench

Single-edge PRBS bit-error-rate checker for serial link test benches and on-chip BIST. It consumes a differential bit stream, one bit per clock, as produced by the differential delay line / error injector stage. It self-synchronises a local LFSR to the incoming PRBS7/15/31 pattern, declares lock, and then counts received bits, bit errors and lock losses. Its error count is compared directly against the injector's `errors` output to validate the link.

---
 rtl/prbs_checker.sv | 187 ++++++++++++++++++
 tb/tb_prbs_checker.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// PRBS7/15/31 bit-error-rate checker: self-synchronising LFSR, lock FSM,
// saturating error/bit/lock-loss counters on a differential input.
module prbs_checker #(
   parameter int unsigned prbs          = 7,
   parameter int unsigned lock_count    = 32,
   parameter int unsigned unlock_errors = 8,
   parameter int unsigned window        = 128
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        clear,
   input  logic        in_p,
   input  logic        in_n,
   output logic        locked,
   output logic [63:0] errors,
   output logic [63:0] bits,
   output logic [15:0] lock_losses
);

   localparam int unsigned tap = (prbs == 31) ? 28 : (prbs == 15) ? 14 : 6;

   localparam logic [5:0]  prbs_w   = 6'(prbs);
   localparam logic [15:0] lock_w   = 16'(lock_count);
   localparam logic [7:0]  unlock_w = 8'(unlock_errors);
   localparam logic [15:0] window_w = 16'(window);

   typedef enum logic [1:0] {
      IDLE,
      SEED,
      VERIFY,
      LOCKED
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [prbs-1:0] sr;
   logic [prbs-1:0] sr_next;
   logic [5:0]      seed_cnt;
   logic [5:0]      seed_next;
   logic [5:0]      seed_inc;
   logic [15:0]     match_cnt;
   logic [15:0]     match_next;
   logic [15:0]     match_inc;
   logic [15:0]     win_cnt;
   logic [15:0]     win_next;
   logic [15:0]     win_inc;
   logic [7:0]      win_err;
   logic [7:0]      win_err_next;
   logic [7:0]      win_err_inc;

   logic valid;
   logic rx;
   logic pred;
   logic hit;
   logic miss;
   logic inc_bits;
   logic inc_err;
   logic inc_loss;

   assign valid       = in_p ^ in_n;
   assign rx          = in_p;
   assign pred        = sr[prbs-1] ^ sr[tap-1];
   // An all-zero register predicts zeros forever, so it never counts as a match.
   assign hit         = valid && (rx == pred) && (sr != '0);
   assign miss        = !valid || (rx != pred);
   assign seed_inc    = seed_cnt + 6'd1;
   assign match_inc   = match_cnt + 16'd1;
   assign win_inc     = win_cnt + 16'd1;
   assign win_err_inc = win_err + 8'd1;

   always_comb begin
      state_next   = state;
      sr_next      = sr;
      seed_next    = seed_cnt;
      match_next   = match_cnt;
      win_next     = win_cnt;
      win_err_next = win_err;
      inc_bits     = 1'b0;
      inc_err      = 1'b0;
      inc_loss     = 1'b0;

      if (!enable) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               state_next = SEED;
               seed_next  = '0;
            end

            SEED: begin
               if (!valid) begin
                  seed_next = '0;
               end else begin
                  sr_next   = {sr[prbs-2:0], rx};
                  seed_next = seed_inc;
                  if (seed_inc == prbs_w) begin
                     state_next = VERIFY;
                     match_next = '0;
                  end
               end
            end

            VERIFY: begin
               sr_next = {sr[prbs-2:0], rx};
               if (hit) begin
                  match_next = match_inc;
                  if (match_inc == lock_w) begin
                     state_next   = LOCKED;
                     win_next     = '0;
                     win_err_next = '0;
                  end
               end else begin
                  match_next = '0;
               end
            end

            LOCKED: begin
               // Free-running on the prediction so a flipped bit costs one error.
               sr_next  = {sr[prbs-2:0], pred};
               inc_bits = 1'b1;
               win_next = win_inc;
               if (miss) begin
                  inc_err      = 1'b1;
                  win_err_next = win_err_inc;
               end
               if (miss && (win_err_inc == unlock_w)) begin
                  state_next = SEED;
                  inc_loss   = 1'b1;
                  seed_next  = '0;
               end else if (win_inc == window_w) begin
                  win_next     = '0;
                  win_err_next = '0;
               end
            end

            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         sr        <= '0;
         seed_cnt  <= '0;
         match_cnt <= '0;
         win_cnt   <= '0;
         win_err   <= '0;
         locked    <= 1'b0;
      end else begin
         state     <= state_next;
         sr        <= sr_next;
         seed_cnt  <= seed_next;
         match_cnt <= match_next;
         win_cnt   <= win_next;
         win_err   <= win_err_next;
         locked    <= (state_next == LOCKED);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         errors      <= '0;
         bits        <= '0;
         lock_losses <= '0;
      end else if (clear) begin
         errors      <= '0;
         bits        <= '0;
         lock_losses <= '0;
      end else begin
         if (inc_err && (errors != '1)) begin
            errors <= errors + 64'd1;
         end
         if (inc_bits && (bits != '1)) begin
            bits <= bits + 64'd1;
         end
         if (inc_loss && (lock_losses != '1)) begin
            lock_losses <= lock_losses + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed self-checking bench for prbs_checker: PRBS7 default instance and a
// PRBS31 / lock_count=1 instance sharing the differential input.
module tb_prbs_checker;

   logic        clock;
   logic        reset;
   logic        clear;
   logic        en7;
   logic        en31;
   logic        in_p;
   logic        in_n;
   logic        locked7;
   logic [63:0] errors7;
   logic [63:0] bits7;
   logic [15:0] losses7;
   logic        locked31;
   logic [63:0] errors31;
   logic [63:0] bits31;
   logic [15:0] losses31;

   int          total;
   int          bad;
   int          mode;
   logic [30:0] gen;

   prbs_checker dut7 (
      .clock       (clock),
      .reset       (reset),
      .enable      (en7),
      .clear       (clear),
      .in_p        (in_p),
      .in_n        (in_n),
      .locked      (locked7),
      .errors      (errors7),
      .bits        (bits7),
      .lock_losses (losses7)
   );

   prbs_checker #(
      .prbs       (31),
      .lock_count (1)
   ) dut31 (
      .clock       (clock),
      .reset       (reset),
      .enable      (en31),
      .clear       (clear),
      .in_p        (in_p),
      .in_n        (in_n),
      .locked      (locked31),
      .errors      (errors31),
      .bits        (bits31),
      .lock_losses (losses31)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Drives the next pattern bit; flip inverts both legs, bad forces in_p == in_n.
   task automatic send(input logic flip, input logic bad);
      logic b;
      b    = (mode == 31) ? (gen[30] ^ gen[27]) : (gen[6] ^ gen[5]);
      gen  = {gen[29:0], b};
      in_p = b ^ flip;
      in_n = bad ? in_p : ~in_p;
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      en7   = 1'b0;
      en31  = 1'b0;
      clear = 1'b0;
      in_p  = 1'b0;
      in_n  = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic acquire7();
      do_reset();
      mode = 7;
      gen  = 31'h7F;
      en7  = 1'b1;
      tick();
      repeat (39) send(1'b0, 1'b0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      en7 = 1'b0; en31 = 1'b0; clear = 1'b0; in_p = 1'b0; in_n = 1'b1;
      #2;
      total++; if (locked7 !== 1'b0) begin bad++; $display("FAIL reset_locked got=%0d exp=0", locked7); end
      total++; if (errors7 !== 64'd0) begin bad++; $display("FAIL reset_errors got=%0d exp=0", errors7); end
      total++; if (bits7 !== 64'd0) begin bad++; $display("FAIL reset_bits got=%0d exp=0", bits7); end
      total++; if (losses7 !== 16'd0) begin bad++; $display("FAIL reset_losses got=%0d exp=0", losses7); end
   endtask

   task automatic test_acquire();
      do_reset();
      mode = 7;
      gen  = 31'h7F;
      en7  = 1'b1;
      tick();
      total++; if (locked7 !== 1'b0) begin bad++; $display("FAIL acq_edge1 got=%0d exp=0", locked7); end
      for (int e = 2; e <= 40; e++) begin
         send(1'b0, 1'b0);
         if (e == 39) begin
            total++; if (locked7 !== 1'b0) begin bad++; $display("FAIL acq_edge39 got=%0d exp=0", locked7); end
         end
      end
      total++; if (locked7 !== 1'b1) begin bad++; $display("FAIL acq_edge40 got=%0d exp=1", locked7); end
      repeat (1000) send(1'b0, 1'b0);
      total++; if (bits7 !== 64'd1000) begin bad++; $display("FAIL acq_bits got=%0d exp=1000", bits7); end
      total++; if (errors7 !== 64'd0) begin bad++; $display("FAIL acq_errors got=%0d exp=0", errors7); end
      total++; if (losses7 !== 16'd0) begin bad++; $display("FAIL acq_losses got=%0d exp=0", losses7); end
   endtask

   task automatic test_isolated();
      for (int i = 0; i < 2000; i++) begin
         send((i % 200) == 100, 1'b0);
      end
      total++; if (errors7 !== 64'd10) begin bad++; $display("FAIL iso_errors got=%0d exp=10", errors7); end
      total++; if (locked7 !== 1'b1) begin bad++; $display("FAIL iso_locked got=%0d exp=1", locked7); end
      total++; if (bits7 !== 64'd3000) begin bad++; $display("FAIL iso_bits got=%0d exp=3000", bits7); end
      total++; if (losses7 !== 16'd0) begin bad++; $display("FAIL iso_losses got=%0d exp=0", losses7); end
   endtask

   task automatic test_burst();
      acquire7();
      for (int i = 0; i <= 70; i++) begin
         send((i % 10) == 0, 1'b0);
         if (i == 69) begin
            total++; if (locked7 !== 1'b1) begin bad++; $display("FAIL burst_7th got=%0d exp=1", locked7); end
         end
      end
      total++; if (locked7 !== 1'b0) begin bad++; $display("FAIL burst_8th got=%0d exp=0", locked7); end
      total++; if (errors7 !== 64'd8) begin bad++; $display("FAIL burst_errors got=%0d exp=8", errors7); end
      total++; if (losses7 !== 16'd1) begin bad++; $display("FAIL burst_losses got=%0d exp=1", losses7); end
      total++; if (bits7 !== 64'd71) begin bad++; $display("FAIL burst_bits got=%0d exp=71", bits7); end
      for (int i = 1; i <= 39; i++) begin
         send(1'b0, 1'b0);
         if (i == 38) begin
            total++; if (locked7 !== 1'b0) begin bad++; $display("FAIL relock_early got=%0d exp=0", locked7); end
         end
      end
      total++; if (locked7 !== 1'b1) begin bad++; $display("FAIL relock got=%0d exp=1", locked7); end
      total++; if (errors7 !== 64'd8) begin bad++; $display("FAIL relock_errors got=%0d exp=8", errors7); end
   endtask

   task automatic test_degenerate();
      logic seen;
      do_reset();
      mode = 7;
      gen  = 31'h7F;
      en7  = 1'b1;
      tick();
      in_p = 1'b1;
      in_n = 1'b1;
      repeat (20) tick();
      for (int e = 22; e <= 60; e++) begin
         send(1'b0, 1'b0);
         if (e == 59) begin
            total++; if (locked7 !== 1'b0) begin bad++; $display("FAIL degen_edge59 got=%0d exp=0", locked7); end
         end
      end
      total++; if (locked7 !== 1'b1) begin bad++; $display("FAIL degen_edge60 got=%0d exp=1", locked7); end

      do_reset();
      en7  = 1'b1;
      seen = 1'b0;
      in_p = 1'b0;
      in_n = 1'b1;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (locked7) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL zero_locked got=%0d exp=0", seen); end
      total++; if (bits7 !== 64'd0) begin bad++; $display("FAIL zero_bits got=%0d exp=0", bits7); end
   endtask

   task automatic test_prbs31();
      do_reset();
      mode = 31;
      gen  = 31'h1234567;
      en31 = 1'b1;
      tick();
      for (int e = 2; e <= 33; e++) begin
         send(1'b0, 1'b0);
         if (e == 32) begin
            total++; if (locked31 !== 1'b0) begin bad++; $display("FAIL p31_edge32 got=%0d exp=0", locked31); end
         end
      end
      total++; if (locked31 !== 1'b1) begin bad++; $display("FAIL p31_edge33 got=%0d exp=1", locked31); end
      for (int k = 32; k < 150; k++) begin
         send(k == 100, 1'b0);
      end
      total++; if (errors31 !== 64'd1) begin bad++; $display("FAIL p31_errors got=%0d exp=1", errors31); end
      total++; if (bits31 !== 64'd118) begin bad++; $display("FAIL p31_bits got=%0d exp=118", bits31); end
      clear = 1'b1;
      send(1'b1, 1'b0);
      clear = 1'b0;
      total++; if (errors31 !== 64'd0) begin bad++; $display("FAIL p31_clear_errors got=%0d exp=0", errors31); end
      total++; if (bits31 !== 64'd0) begin bad++; $display("FAIL p31_clear_bits got=%0d exp=0", bits31); end
      send(1'b1, 1'b0);
      total++; if (errors31 !== 64'd1) begin bad++; $display("FAIL p31_after_clear got=%0d exp=1", errors31); end
      total++; if (locked31 !== 1'b1) begin bad++; $display("FAIL p31_locked got=%0d exp=1", locked31); end
   endtask

   task automatic test_async_reset();
      acquire7();
      for (int i = 0; i < 50; i++) begin
         send((i == 10) || (i == 20), 1'b0);
      end
      total++; if (errors7 !== 64'd2) begin bad++; $display("FAIL ar_pre_errors got=%0d exp=2", errors7); end
      total++; if (bits7 !== 64'd50) begin bad++; $display("FAIL ar_pre_bits got=%0d exp=50", bits7); end
      #2;
      reset = 1'b1;
      #1;
      total++; if (locked7 !== 1'b0) begin bad++; $display("FAIL ar_locked got=%0d exp=0", locked7); end
      total++; if (errors7 !== 64'd0) begin bad++; $display("FAIL ar_errors got=%0d exp=0", errors7); end
      total++; if (bits7 !== 64'd0) begin bad++; $display("FAIL ar_bits got=%0d exp=0", bits7); end
      total++; if (losses7 !== 16'd0) begin bad++; $display("FAIL ar_losses got=%0d exp=0", losses7); end
      tick();
      reset = 1'b0;
      tick();
      total++; if (locked7 !== 1'b0) begin bad++; $display("FAIL ar_after got=%0d exp=0", locked7); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      mode  = 7;
      gen   = 31'h7F;
      test_reset();
      test_acquire();
      test_isolated();
      test_burst();
      test_degenerate();
      test_prbs31();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
